// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, computes W[16..63] at UNROLL words/cycle (48/UNROLL cycles).
// Output schedule held in HOLD until w_ready; in_ready only while IDLE, so upstream stalls during expansion.
module sha_msg_sched #(
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:15][31:0] block_in,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [0:63][31:0] W_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                   state;
  logic [6:0]               idx;
  logic [5:0]               base;
  logic [UNROLL-1:0][31:0]  nw;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign base     = idx[5:0];
  assign in_ready = (state == IDLE);
  assign w_valid  = (state == HOLD);

  // Only the t-2 tap can land on a word computed this same cycle (UNROLL <= 4 < 7).
  for (genvar g = 0; g < UNROLL; g++) begin : g_word
    logic [31:0] tap2;
    if (g >= 2) begin : g_chain
      assign tap2 = nw[g-2];
    end else begin : g_reg
      assign tap2 = W_out[base + 6'(g) - 6'd2];
    end
    assign nw[g] = sig1(tap2)
                 + W_out[base + 6'(g) - 6'd7]
                 + sig0(W_out[base + 6'(g) - 6'd15])
                 + W_out[base + 6'(g) - 6'd16];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 7'd16;
      W_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            W_out[0:15]  <= block_in;
            W_out[16:63] <= '0;
            idx          <= 7'd16;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          for (int u = 0; u < UNROLL; u++) begin
            W_out[base + 6'(u)] <= nw[u];
          end
          idx <= idx + 7'(UNROLL);
          if (idx + 7'(UNROLL) == 7'd64) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (w_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_sched.sv
// Bench for sha_msg_sched: three instances (UNROLL 1, 2, 4) checked against a plain-arithmetic SHA-256 schedule model.
module tb_sha_msg_sched;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:15][31:0] block_in;
  logic              iv [3];
  logic              wr [3];
  logic              ir [3];
  logic              wv [3];
  logic [0:63][31:0] wo [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sha_msg_sched #(.UNROLL(1)) u1 (.clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .block_in(block_in), .w_valid(wv[0]), .w_ready(wr[0]), .W_out(wo[0]));
  sha_msg_sched #(.UNROLL(2)) u2 (.clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .block_in(block_in), .w_valid(wv[1]), .w_ready(wr[1]), .W_out(wo[1]));
  sha_msg_sched #(.UNROLL(4)) u4 (.clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .block_in(block_in), .w_valid(wv[2]), .w_ready(wr[2]), .W_out(wo[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rotr(input int unsigned x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [0:63][31:0] model(input logic [0:15][31:0] b);
    int unsigned w [64];
    int unsigned s0, s1;
    logic [0:63][31:0] r;
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) r[t] = w[t];
    return r;
  endfunction

  function automatic logic [0:15][31:0] rand_blk();
    logic [0:15][31:0] b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic check_words(input int k, input logic [0:63][31:0] exp, input string tag);
    for (int i = 0; i < 64; i++) check($sformatf("%s W[%0d]", tag, i), wo[k][i], exp[i]);
  endtask

  // Called at the negedge after the accept edge; n = edges until w_valid seen.
  task automatic wait_wv(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!wv[k] && n < 200);
  endtask

  task automatic run_blk(input int k, input logic [0:15][31:0] blk, input string tag);
    int n;
    @(negedge clk);
    block_in = blk;
    iv[k] = 1'b1;
    wr[k] = 1'b1;
    check({tag, " in_ready"}, ir[k], 1);
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0;
    wait_wv(k, n);
    check({tag, " latency"}, n, 48 >> k);
    check_words(k, model(blk), tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, " in_ready after"}, ir[k], 1);
    check({tag, " w_valid after"}, wv[k], 0);
  endtask

  initial begin
    logic [0:15][31:0] a, b;
    logic [0:63][31:0] ea;
    int n, accn;
    logic prev, seen, saw;

    reset = 1'b1;
    block_in = '0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      wr[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset in_ready u%0d", k), ir[k], 1);
      check($sformatf("reset w_valid u%0d", k), wv[k], 0);
      check($sformatf("reset W_out zero u%0d", k), (wo[k] == '0), 1);
    end

    // "abc" padded block
    a = '0;
    a[0] = 32'h61626380;
    a[15] = 32'h00000018;
    run_blk(0, a, "abc");
    check("abc W16 const", wo[0][16], 32'h61626380);
    check("abc W17 const", wo[0][17], 32'h000F0000);

    for (int k = 0; k < 3; k++) run_blk(k, '0, $sformatf("zero u%0d", k));
    for (int k = 0; k < 3; k++) run_blk(k, '1, $sformatf("ones u%0d", k));
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) run_blk(k, rand_blk(), $sformatf("rand%0d u%0d", r, k));

    // Backpressure: hold output for 20 cycles, in_valid pulses must be ignored
    a = rand_blk();
    ea = model(a);
    @(negedge clk);
    block_in = a;
    iv[0] = 1'b1;
    wr[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_wv(0, n);
    check("bp latency", n, 48);
    for (int c = 0; c < 20; c++) begin
      iv[0] = (c == 5 || c == 10);
      block_in = rand_blk();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp stable c%0d", c), (wo[0] == ea), 1);
      check($sformatf("bp in_ready c%0d", c), ir[0], 0);
      check($sformatf("bp w_valid c%0d", c), wv[0], 1);
    end
    iv[0] = 1'b0;
    wr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp in_ready release", ir[0], 1);
    check("bp w_valid release", wv[0], 0);
    check("bp W_out kept in idle", (wo[0] == ea), 1);

    // Back-to-back: in_valid held high across the handoff
    a = rand_blk();
    b = rand_blk();
    ea = model(a);
    @(negedge clk);
    block_in = a;
    iv[0] = 1'b1;
    wr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    block_in = b;
    n = 0;
    accn = 0;
    prev = ir[0];
    seen = 1'b0;
    while (n < 200 && accn == 0) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (wv[0] && !seen) begin
        seen = 1'b1;
        check("b2b first latency", n, 48);
        check_words(0, ea, "b2b first");
      end
      if (prev && iv[0]) accn = n;
      prev = ir[0];
    end
    check("b2b second accept edge", accn, 50);
    iv[0] = 1'b0;
    wait_wv(0, n);
    check("b2b second latency", n, 48);
    check_words(0, model(b), "b2b second");
    @(posedge clk);
    @(negedge clk);

    // Async reset mid-expansion (idx = 30)
    @(negedge clk);
    block_in = rand_blk();
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("arst in_ready", ir[0], 1);
    check("arst w_valid", wv[0], 0);
    check("arst W_out zero", (wo[0] == '0), 1);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (wv[0]) saw = 1'b1;
    end
    check("arst no w_valid", saw, 0);
    run_blk(0, rand_blk(), "post-reset u0");
    run_blk(2, rand_blk(), "post-reset u2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
